div_unit: RTL and testbench

Iterative RV32M divider for DIV, DIVU, REM and REMU. It sits in the execute stage and consumes the two register-file read operands (rs1 as dividend, rs2 as divisor). After a multi-cycle computation it delivers a result and destination register index to the writeback path, which drives the register-file write port. While it works, it raises `busy` so the hazard logic stalls the front end.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 163 ++++++++++++++++
 tb/tb_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package riscv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} pair.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic [DATA_WIDTH-1:0] quo_out
);

    logic [DATA_WIDTH+1:0] rem_sh;
    logic [DATA_WIDTH+1:0] diff;

    // One guard bit above the remainder so the borrow is always a clean sign bit.
    assign rem_sh = {rem_in, quo_in[DATA_WIDTH-1]};
    assign diff   = rem_sh - {2'b00, divisor};

    always_comb begin
        rem_out = rem_sh[DATA_WIDTH:0];
        quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
        if (!diff[DATA_WIDTH+1]) begin
            rem_out    = diff[DATA_WIDTH:0];
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle on magnitudes.
// Define DIV_EARLY_OUT_EN to complete divide-by-zero and signed overflow directly from IDLE.
module div_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rd_out
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    div_state_t            state_q, state_d;
    div_op_t               op_q, op_d, op_sel;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
    logic [DATA_WIDTH:0]   rem_q, rem_d, step_rem;
    logic [DATA_WIDTH-1:0] quo_q, quo_d, step_quo;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d, result_q, result_d;
    logic [DATA_WIDTH-1:0] final_quo, final_rem;
    logic [5:0]            count_q, count_d;
    logic                  neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic                  zero_q, zero_d, done_q, done_d;
    logic                  signed_op, in_zero;

    assign op_sel    = div_op_t'(op);
    assign signed_op = (op_sel == DIV) || (op_sel == REM);
    assign in_zero   = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic in_ovf, in_rem;
    assign in_ovf = signed_op && (dividend == MIN_NEG) && (divisor == '1);
    assign in_rem = (op_sel == REM) || (op_sel == REMU);
`endif

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
    assign final_quo = (neg_quo_q && !zero_q) ? -step_quo : step_quo;
    assign final_rem = neg_rem_q ? -step_rem[DATA_WIDTH-1:0] : step_rem[DATA_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        count_d   = count_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d      = op_sel;
                    rd_d      = rd_in;
                    rem_d     = '0;
                    count_d   = '0;
                    quo_d     = (signed_op && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
                    dvsr_d    = (signed_op && divisor[DATA_WIDTH-1]) ? -divisor : divisor;
                    neg_quo_d = signed_op && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                    neg_rem_d = signed_op && dividend[DATA_WIDTH-1];
                    zero_d    = in_zero;
                    state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (in_zero || in_ovf) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        rd_out_d = rd_in;
                        if (in_zero) begin
                            result_d = in_rem ? dividend : '1;
                        end else begin
                            result_d = in_rem ? '0 : MIN_NEG;
                        end
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + 6'd1;
                    // Final step: fold sign correction into the result register write.
                    if (count_q == LAST_STEP) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        rd_out_d = rd_q;
                        result_d = ((op_q == REM) || (op_q == REMU)) ? final_rem : final_quo;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            rd_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            count_q   <= count_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = done_q && !flush;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases plus randomized ops vs an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [31:0] dividend, divisor;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .rd_in    (rd_in),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'h0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    // Launch one op and wait (bounded) for done; latency counts edges from the sampling edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                          output int lat, output int busy_cnt, output logic [31:0] res,
                          output logic [4:0] rdo, output bit ok);
        @(negedge clk);
        for (int k = 0; k < 4 && done; k++) @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b; rd_in = r;
        lat = 0; busy_cnt = 0; ok = 1'b0; res = 'x; rdo = 'x;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                start = 1'b0;
                dividend = $urandom; divisor = $urandom; rd_in = 5'($urandom);
            end
            lat++;
            if (busy) busy_cnt++;
            if (done) begin
                ok = 1'b1; res = result; rdo = rd_out;
                break;
            end
        end
        $display("op=%0d a=%h b=%h rd=%0d -> result=%h rd_out=%0d latency=%0d busy_cycles=%0d",
                 o, a, b, r, res, rdo, lat, busy_cnt);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        dividend = '0; divisor = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
        n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL reset_rd_out got=%h want=0", rd_out); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency;
        int lat, bc; logic [31:0] res; logic [4:0] rdo; bit ok;
        run_op(2'b01, 32'd100, 32'd7, 5'd3, lat, bc, res, rdo, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL divu_timeout no done within bound"); end
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result got=%h want=%h", res, 32'd14); end
        n_checks++; if (rdo !== 5'd3) begin n_fail++; $display("FAIL divu_rd got=%0d want=3", rdo); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got=%0d want=33", lat); end
        n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL divu_busy_cycles got=%0d want=32", bc); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got=%b want=0", done); end
        run_op(2'b11, 32'd100, 32'd7, 5'd0, lat, bc, res, rdo, ok);
        n_checks++; if (!ok || res !== 32'd2) begin n_fail++; $display("FAIL remu_result got=%h want=%h ok=%0d", res, 32'd2, ok); end
        n_checks++; if (rdo !== 5'd0) begin n_fail++; $display("FAIL remu_rd0 got=%0d want=0", rdo); end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
    } vec_t;

    task automatic test_directed;
        vec_t v[$];
        int lat, bc; logic [31:0] res; logic [4:0] rdo; bit ok;
        v.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD});
        v.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF});
        v.push_back('{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD});
        v.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1});
        v.push_back('{2'b00, 32'd5,         32'd0,        32'hFFFF_FFFF});
        v.push_back('{2'b10, 32'd5,         32'd0,        32'd5});
        v.push_back('{2'b00, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF});
        v.push_back('{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB});
        v.push_back('{2'b01, 32'd5,         32'd0,        32'hFFFF_FFFF});
        v.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        v.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, 5'(i + 1), lat, bc, res, rdo, ok);
            n_checks++;
            if (!ok || res !== v[i].want) begin
                n_fail++;
                $display("FAIL directed_%0d_result got=%h want=%h ok=%0d", i, res, v[i].want, ok);
            end
            n_checks++;
            if (lat !== ref_latency(v[i].o, v[i].a, v[i].b)) begin
                n_fail++;
                $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, ref_latency(v[i].o, v[i].a, v[i].b));
            end
        end
    endtask

    task automatic test_flush;
        int lat, bc; logic [31:0] res; logic [4:0] rdo; bit ok;
        int seen = 0;
        @(negedge clk);
        for (int k = 0; k < 4 && done; k++) @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'hDEAD_BEEF; divisor = 32'd3; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        if (done) seen++;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got=%b want=1", busy); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got=%b want=0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d done pulses want=0", seen); end
        $display("flushed op a=deadbeef b=3 rd=9 at CALC cycle 10");
        run_op(2'b01, 32'd9, 32'd3, 5'd17, lat, bc, res, rdo, ok);
        n_checks++; if (!ok || res !== 32'd3) begin n_fail++; $display("FAIL post_flush_result got=%h want=3 ok=%0d", res, ok); end
        n_checks++; if (rdo !== 5'd17) begin n_fail++; $display("FAIL post_flush_rd got=%0d want=17", rdo); end
    endtask

    task automatic test_start_in_calc;
        int lat = 0;
        bit ok = 1'b0;
        logic [31:0] res = 'x;
        logic [4:0]  rdo = 'x;
        @(negedge clk);
        for (int k = 0; k < 4 && done; k++) @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'hFFFF_FF9C; divisor = 32'd7; rd_in = 5'd4;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (i == 0) start = 1'b0;
            if (i == 5) begin
                start = 1'b1; op = 2'b11; dividend = 32'd55; divisor = 32'd10; rd_in = 5'd30;
            end
            if (i == 6) start = 1'b0;
            if (done) begin ok = 1'b1; res = result; rdo = rd_out; break; end
        end
        $display("op=0 a=ffffff9c b=7 rd=4 with start in CALC -> result=%h rd_out=%0d latency=%0d", res, rdo, lat);
        n_checks++; if (!ok || res !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL ignore_start_result got=%h want=fffffff2 ok=%0d", res, ok); end
        n_checks++; if (rdo !== 5'd4) begin n_fail++; $display("FAIL ignore_start_rd got=%0d want=4", rdo); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_start_latency got=%0d want=33", lat); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_no_relaunch busy got=%b want=0", busy); end
    endtask

    task automatic test_random;
        int lat, bc; logic [31:0] res, a, b, want; logic [4:0] rdo, r; logic [1:0] o; bit ok;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: b = 32'($urandom_range(1, 1000));
                4: b = -32'($urandom_range(1, 1000));
                default: b = $urandom;
            endcase
            r = 5'($urandom);
            want = ref_result(o, a, b);
            run_op(o, a, b, r, lat, bc, res, rdo, ok);
            n_checks++;
            if (!ok || res !== want || rdo !== r) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got=%h/rd%0d want=%h/rd%0d ok=%0d", n, o, a, b, res, rdo, want, r, ok);
            end
            n_checks++;
            if (lat !== ref_latency(o, a, b)) begin
                n_fail++;
                $display("FAIL random_%0d_latency got=%0d want=%0d", n, lat, ref_latency(o, a, b));
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc; logic [31:0] res; logic [4:0] rdo; bit ok;
        int seen = 0;
        run_op(2'b01, 32'd1000, 32'd9, 5'd21, lat, bc, res, rdo, ok);
        @(negedge clk);
        for (int k = 0; k < 4 && done; k++) @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'd12345; divisor = 32'd11; rd_in = 5'd12;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got=%b want=0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL mid_reset_result got=%h want=0", result); end
        n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL mid_reset_rd_out got=%h want=0", rd_out); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        $display("reset applied mid-CALC, %0d done pulses afterwards", seen);
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_done got=%0d want=0", seen); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd3, 5'd8, lat, bc, res, rdo, ok);
        n_checks++; if (!ok || res !== 32'hFFFF_FFFF || rdo !== 5'd8) begin n_fail++; $display("FAIL post_reset_op got=%h/rd%0d want=ffffffff/rd8 ok=%0d", res, rdo, ok); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_flush();
        test_start_in_calc();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
